mem_row_loader: RTL and testbench

- Upstream feeder for vectored_mac_fifo.
- On a start pulse, it reads NUM_ROWS 64-bit rows from mem_wrapper over the read/waitrequest/readdatavalid handshake.
- Each row is split into LANES bytes. The bytes are pushed serially into the B FIFO (row 0) or the A FIFO lane for that row (rows 1..LANES).
- Replaces the ad-hoc FILL states in the top-level FSM. The top level starts EXEC when done rises.

---
 rtl/mem_row_loader.sv | 186 ++++++++++++++++++
 tb/tb_mem_row_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_row_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_row_loader: fetches NUM_ROWS memory rows and streams their bytes into the B / A FIFOs.
// Rev 1.0 -- define LOADER_CHECKSUM_EN to add a 16-bit running sum of pushed bytes.
// ---------------------------------------------------------------------------
module mem_row_loader #(
  parameter int          DATA_WIDTH = 8,
  parameter int          LANES      = 8,
  parameter int          NUM_ROWS   = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [31:0]           mem_address,
  output logic                  mem_read,
  input  logic [63:0]           mem_readdata,
  input  logic                  mem_readdatavalid,
  input  logic                  mem_waitrequest,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  b_wren,
  output logic [LANES-1:0]      a_wren,
  input  logic                  b_full,
  input  logic [LANES-1:0]      a_full,
  output logic                  busy,
  output logic                  done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int c_ROW_W = 64;
  localparam int c_RW    = $clog2(NUM_ROWS + 1);
  localparam int c_BW    = $clog2(LANES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_RW-1:0]       r_row, w_row_nxt;
  logic [c_BW-1:0]       r_byte, w_byte_nxt;
  logic [c_ROW_W-1:0]    r_buf, w_buf_nxt;
  logic                  r_mem_read, w_read_nxt;
  logic [31:0]           r_mem_address, w_addr_nxt;
  logic                  r_b_wren, w_b_wren_nxt;
  logic [LANES-1:0]      r_a_wren, w_a_wren_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;

  logic [LANES-1:0]      w_a_sel;
  logic                  w_tgt_full;
  logic [DATA_WIDTH-1:0] w_cur_byte;

  // Row 0 feeds B; row k feeds A lane k-1.
  assign w_a_sel    = (r_row == '0) ? '0
                    : ({{(LANES-1){1'b0}}, 1'b1} << (r_row - c_RW'(1)));
  assign w_tgt_full = (r_row == '0) ? b_full : |(a_full & w_a_sel);
  // The buffer shifts left after every push, so the top byte is always next.
  assign w_cur_byte = r_buf[c_ROW_W-1 -: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_byte        <= '0;
      r_buf         <= '0;
      r_mem_read    <= 1'b0;
      r_mem_address <= '0;
      r_b_wren      <= 1'b0;
      r_a_wren      <= '0;
      r_wdata       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_byte        <= w_byte_nxt;
      r_buf         <= w_buf_nxt;
      r_mem_read    <= w_read_nxt;
      r_mem_address <= w_addr_nxt;
      r_b_wren      <= w_b_wren_nxt;
      r_a_wren      <= w_a_wren_nxt;
      r_wdata       <= w_wdata_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_byte_nxt   = r_byte;
    w_buf_nxt    = r_buf;
    w_read_nxt   = 1'b0;
    w_addr_nxt   = r_mem_address;
    w_b_wren_nxt = 1'b0;
    w_a_wren_nxt = '0;
    w_wdata_nxt  = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_REQ;
          w_row_nxt   = '0;
          w_byte_nxt  = '0;
          w_read_nxt  = 1'b1;
          w_addr_nxt  = BASE_ADDR;
        end
      end
      S_REQ: begin
        w_read_nxt = 1'b1;
        if (r_mem_read && !mem_waitrequest) begin
          w_read_nxt = 1'b0;
          // Zero-latency return is captured straight out of the request cycle.
          if (mem_readdatavalid) begin
            w_buf_nxt   = mem_readdata;
            w_byte_nxt  = '0;
            w_state_nxt = S_PUSH;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          w_buf_nxt   = mem_readdata;
          w_byte_nxt  = '0;
          w_state_nxt = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!w_tgt_full) begin
          w_wdata_nxt  = w_cur_byte;
          w_b_wren_nxt = (r_row == '0);
          w_a_wren_nxt = w_a_sel;
          w_buf_nxt    = r_buf << DATA_WIDTH;
          w_byte_nxt   = r_byte + c_BW'(1);
          if (r_byte == c_BW'(LANES - 1)) begin
            w_byte_nxt = '0;
            if (r_row == c_RW'(NUM_ROWS - 1)) begin
              w_state_nxt = S_DONE;
            end else begin
              w_row_nxt   = r_row + c_RW'(1);
              w_state_nxt = S_REQ;
              w_read_nxt  = 1'b1;
              w_addr_nxt  = BASE_ADDR + 32'(r_row) + 32'd1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT) || (w_state_nxt == S_PUSH);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst || (((r_state == S_IDLE) || (r_state == S_DONE)) && start)) begin
      r_checksum <= '0;
    end else if (w_b_wren_nxt || (|w_a_wren_nxt)) begin
      r_checksum <= r_checksum + 16'(w_cur_byte);
    end
  end

  assign checksum = r_checksum;
`endif

  assign mem_address = r_mem_address;
  assign mem_read    = r_mem_read;
  assign fifo_wdata  = r_wdata;
  assign b_wren      = r_b_wren;
  assign a_wren      = r_a_wren;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_row_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_row_loader: directed bench with a 2-cycle-latency memory and FIFO-side push monitor.
// Rev 1.0 -- checksum checks are compiled in when LOADER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_row_loader;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [63:0] mem_readdata = '0;
  logic        mem_readdatavalid = 1'b0;
  logic        mem_waitrequest = 1'b0;
  logic [7:0]  fifo_wdata;
  logic        b_wren;
  logic [7:0]  a_wren;
  logic        b_full = 1'b0;
  logic [7:0]  a_full = '0;
  logic        busy, done;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_row_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_waitrequest   (mem_waitrequest),
    .fifo_wdata        (fifo_wdata),
    .b_wren            (b_wren),
    .a_wren            (a_wren),
    .b_full            (b_full),
    .a_full            (a_full),
    .busy              (busy),
    .done              (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Requests from the stimulus process to the monitor process.
  int clr_seq = 0, stray_seq = 0;
  bit wr_arm = 1'b0, stall_arm = 1'b0;

  // Monitor-owned state.
  int clr_seen = 0, stray_seen = 0;
  int n_reads, addr_bad, b_cnt, bad, multi, total;
  int lane_cnt [8];
  int wr_used, wr_hold, stall_left, stall_used, stall_viol, t3, t4;
  int cyc = 0, t_req0 = -1, t_done = -1;
  bit d1 = 1'b0, d2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0;

  function automatic logic [63:0] rowdat(input logic [31:0] a);
    if (a == 32'd0) return 64'h0102030405060708;
    else if (a <= 32'd8) return {8{a[7:0]}};
    else return 64'h0;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      n_reads = 0; addr_bad = 0; b_cnt = 0; bad = 0; multi = 0; total = 0;
      for (int i = 0; i < 8; i++) lane_cnt[i] = 0;
      wr_hold = 0; stall_viol = 0; t3 = -1; t4 = -1; t_req0 = -1; t_done = -1;
    end
    // FIFO side: every asserted wren is one push.
    if (b_wren) begin
      if (fifo_wdata != 8'(b_cnt + 1)) bad++;
      b_cnt++;
      total++;
    end
    for (int i = 0; i < 8; i++) begin
      if (a_wren[i]) begin
        if (fifo_wdata != 8'(i + 1)) bad++;
        lane_cnt[i]++;
        total++;
        if (i == 2 && lane_cnt[2] == 3) t3 = cyc;
        if (i == 2 && lane_cnt[2] == 4) t4 = cyc;
      end
    end
    if ($countones({b_wren, a_wren}) > 1) multi++;
    if (mem_read && t_req0 < 0) t_req0 = cyc;
    if (done && t_done < 0) t_done = cyc;
    // Lane 2 goes full for 4 cycles right after its 3rd byte.
    if (!stall_arm) stall_used = 0;
    if (stall_left > 0) begin
      if (a_wren[2]) stall_viol++;
      stall_left--;
      if (stall_left == 0) a_full[2] = 1'b0;
    end else if (stall_arm && stall_used == 0 && a_wren[2] && lane_cnt[2] == 3) begin
      a_full[2]  = 1'b1;
      stall_left = 4;
      stall_used = 1;
    end
    // Row 3 request sees 5 cycles of waitrequest.
    if (!wr_arm) wr_used = 0;
    mem_waitrequest = wr_arm && mem_read && (mem_address == 32'd3) && (wr_used < 5);
    if (mem_waitrequest) begin
      wr_used++;
      wr_hold++;
    end
    // Memory with 2-cycle read latency.
    mem_readdatavalid = d2;
    mem_readdata      = rowdat(a2);
    d2 = d1;
    a2 = a1;
    d1 = mem_read && !mem_waitrequest && !rst;
    a1 = mem_address;
    if (d1) begin
      if (mem_address != 32'(n_reads)) addr_bad++;
      n_reads++;
    end
    if (stray_seq != stray_seen) begin
      stray_seen        = stray_seq;
      mem_readdatavalid = 1'b1;
      mem_readdata      = '1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_read"}, mem_read, 0);
    chk({p, "_addr"}, mem_address, 0);
    chk({p, "_wren"}, {b_wren, a_wren}, 0);
    chk({p, "_wdata"}, fifo_wdata, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
`ifdef LOADER_CHECKSUM_EN
    chk({p, "_csum"}, checksum, 0);
`endif
  endtask

  task automatic wait_done(input string p);
    int k = 0;
    while (!done && k < 600) begin
      tick();
      k++;
    end
    chk({p, "_done"}, done, 1);
    tick();
  endtask

  task automatic chk_load(input string p);
    chk({p, "_reads"}, n_reads, 9);
    chk({p, "_addr_seq"}, addr_bad, 0);
    chk({p, "_b_cnt"}, b_cnt, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_lane%0d", p, i), lane_cnt[i], 8);
    chk({p, "_bytes"}, bad, 0);
    chk({p, "_pushes"}, total, 72);
    chk({p, "_onehot"}, multi, 0);
`ifdef LOADER_CHECKSUM_EN
    chk({p, "_csum"}, checksum, 16'h0144);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();

    // Basic load.
    clr_seq++;
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    wait_done("basic");
    chk_load("basic");
    chk("basic_cycles", t_done - t_req0, 99);
    repeat (3) tick();
    chk("done_held", done, 1);

    // Waitrequest on row 3, lane 2 backpressure, start while busy.
    clr_seq++;
    wr_arm    = 1'b1;
    stall_arm = 1'b1;
    pulse_start();
    k = 0;
    while (n_reads < 2 && k < 100) begin
      tick();
      k++;
    end
    chk("row1_reached", n_reads, 2);
    pulse_start();
    wait_done("stall");
    chk_load("stall");
    chk("wait_hold", wr_hold, 5);
    chk("full_wren", stall_viol, 0);
    chk("full_gap", t4 - t3, 5);
    wr_arm    = 1'b0;
    stall_arm = 1'b0;

    // Restart from DONE.
    clr_seq++;
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    wait_done("restart");
    chk_load("restart");

    // Reset during row 5 pushes, then a stray return.
    clr_seq++;
    pulse_start();
    k = 0;
    while (lane_cnt[4] < 3 && k < 200) begin
      tick();
      k++;
    end
    chk("row5_reached", lane_cnt[4] >= 3, 1);
    rst = 1'b1;
    tick();
    chk_reset_outs("midrst");
    rst = 1'b0;
    tick();
    clr_seq++;
    stray_seq++;
    repeat (6) tick();
    chk("stray_pushes", total, 0);
    chk("stray_reads", n_reads, 0);
    chk("stray_busy", busy, 0);

    // Fresh load after the abort.
    clr_seq++;
    pulse_start();
    wait_done("reload");
    chk_load("reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
